// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port between two cores.
// One transaction per grant, with an IDLE cycle between grants.
module ram_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_SERVE
  } state_t;

  typedef enum logic [1:0] {
    K_I,
    K_DR,
    K_DW
  } kind_t;

  state_t state_q;
  kind_t  gkind_q;
  kind_t  gkind_d;
  logic   gcore_q;
  logic   gcore_d;
  logic   rr_q;

  logic   req_any;
  logic   rr_has;
  logic   g_req;
  logic   serve;
  logic   done;

  // Next grant: preferred core if it asks, else the other; read beats write beats fetch
  always_comb begin
    req_any = |(iREN | dREN | dWEN);
    rr_has  = iREN[rr_q] | dREN[rr_q] | dWEN[rr_q];
    gcore_d = rr_has ? rr_q : ~rr_q;
    gkind_d = K_I;
    priority case (1'b1)
      dREN[gcore_d]: gkind_d = K_DR;
      dWEN[gcore_d]: gkind_d = K_DW;
      default:       gkind_d = K_I;
    endcase
  end

  // Is the latched request still being held by its owner
  always_comb begin
    g_req = 1'b0;
    unique case (gkind_q)
      K_I:     g_req = iREN[gcore_q];
      K_DR:    g_req = dREN[gcore_q];
      K_DW:    g_req = dWEN[gcore_q];
      default: g_req = 1'b0;
    endcase
    serve = !RST && (state_q == S_SERVE) && g_req;
    done  = serve && (ramstate == ST_ACCESS);
  end

  // RAM side, driven only from the latched grant
  always_comb begin
    ramREN   = serve && (gkind_q != K_DW);
    ramWEN   = serve && (gkind_q == K_DW);
    ramaddr  = '0;
    ramstore = '0;
    if (serve) begin
      ramaddr = (gkind_q == K_I) ? iaddr[gcore_q] : daddr[gcore_q];
      if (gkind_q == K_DW) ramstore = dstore[gcore_q];
    end
  end

  // Core side: stall until completion, read data only on the completing cycle
  always_comb begin
    iwait = iREN;
    dwait = dREN | dWEN;
    iload = '0;
    dload = '0;
    if (done) begin
      if (gkind_q == K_I) begin
        iwait[gcore_q] = 1'b0;
        iload[gcore_q] = ramload;
      end else begin
        dwait[gcore_q] = 1'b0;
        if (gkind_q == K_DR) dload[gcore_q] = ramload;
      end
    end
  end

  // Grant FSM and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      gcore_q <= 1'b0;
      gkind_q <= K_I;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_any) begin
            gcore_q <= gcore_d;
            gkind_q <= gkind_d;
            state_q <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (!g_req) begin
            state_q <= S_IDLE;
          end else if (done) begin
            state_q <= S_IDLE;
            rr_q    <= ~gcore_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized run
// against a transaction-level reference model.
module tb_ram_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int n_checks = 0;
  int n_pass   = 0;

  ram_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1'b1;
    dREN[0] = 1'b1; daddr[0] = 32'h1234;
    iREN[1] = 1'b1; iaddr[1] = 32'h5678;
    ramstate = ACCESS; ramload = 32'hFFFF_0000;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    n_checks++; if ({ramREN, ramWEN} !== 2'b00) $display("FAIL rst_strobes got %b want 00", {ramREN, ramWEN}); else n_pass++;
    n_checks++; if ({ramaddr, ramstore} !== 64'h0) $display("FAIL rst_addr got %h want 0", {ramaddr, ramstore}); else n_pass++;
    n_checks++; if ({iload, dload} !== 128'h0) $display("FAIL rst_loads got %h want 0", {iload, dload}); else n_pass++;
    n_checks++; if ({iwait, dwait} !== 4'b1001) $display("FAIL rst_waits got %b want 1001", {iwait, dwait}); else n_pass++;
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_single_read();
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = FREE;
    #2;
    n_checks++; if (ramREN !== 1'b0) $display("FAIL sr_idle_ren got %b want 0", ramREN); else n_pass++;
    n_checks++; if (dwait[0] !== 1'b1) $display("FAIL sr_idle_wait got %b want 1", dwait[0]); else n_pass++;
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #2;
    n_checks++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h100}) $display("FAIL sr_ram got %b%b %h want 10 100", ramREN, ramWEN, ramaddr); else n_pass++;
    n_checks++; if (dload[0] !== 32'hDEAD_BEEF) $display("FAIL sr_dload got %h want deadbeef", dload[0]); else n_pass++;
    n_checks++; if (dwait[0] !== 1'b0) $display("FAIL sr_done_wait got %b want 0", dwait[0]); else n_pass++;
    @(negedge CLK);
    #2;
    n_checks++; if ({ramREN, dwait[0], dload[0]} !== {2'b01, 32'h0}) $display("FAIL sr_back_idle got %b %b %h want 0 1 0", ramREN, dwait[0], dload[0]); else n_pass++;
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_priority();
    do_reset();
    iREN[1] = 1'b1; dWEN[1] = 1'b1;
    dstore[1] = 32'h55; daddr[1] = 32'h200; iaddr[1] = 32'h300;
    ramstate = ACCESS; ramload = 32'h1234;
    @(negedge CLK);
    #2;
    n_checks++; if ({ramWEN, ramREN, ramstore, ramaddr} !== {2'b10, 32'h55, 32'h200}) $display("FAIL pri_write got %b%b %h %h want 10 55 200", ramWEN, ramREN, ramstore, ramaddr); else n_pass++;
    n_checks++; if ({iwait[1], dwait[1]} !== 2'b10) $display("FAIL pri_waits got %b want 10", {iwait[1], dwait[1]}); else n_pass++;
    @(negedge CLK);
    dWEN[1] = 1'b0;
    #2;
    n_checks++; if ({ramREN, ramWEN, iwait[1]} !== 3'b001) $display("FAIL pri_gap got %b want 001", {ramREN, ramWEN, iwait[1]}); else n_pass++;
    @(negedge CLK);
    #2;
    n_checks++; if ({ramREN, ramaddr, ramstore} !== {1'b1, 32'h300, 32'h0}) $display("FAIL pri_fetch got %b %h %h want 1 300 0", ramREN, ramaddr, ramstore); else n_pass++;
    n_checks++; if ({iwait[1], iload[1]} !== {1'b0, 32'h1234}) $display("FAIL pri_iload got %b %h want 0 1234", iwait[1], iload[1]); else n_pass++;
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    dREN = 2'b11; daddr[0] = 32'hA0; daddr[1] = 32'hB0;
    ramstate = ACCESS;
    for (int t = 0; t < 4; t++) begin
      g = t % 2;
      ramload = 32'hC0DE_0000 + t;
      #2;
      n_checks++; if (ramREN !== 1'b0) $display("FAIL rr_gap%0d got %b want 0", t, ramREN); else n_pass++;
      @(negedge CLK);
      #2;
      n_checks++; if (ramaddr !== (g == 0 ? 32'hA0 : 32'hB0)) $display("FAIL rr_order%0d got %h want core%0d", t, ramaddr, g); else n_pass++;
      n_checks++; if (dwait !== (g == 0 ? 2'b10 : 2'b01)) $display("FAIL rr_wait%0d got %b want other core stalled", t, dwait); else n_pass++;
      n_checks++; if (dload[g] !== ramload || dload[1-g] !== 32'h0) $display("FAIL rr_load%0d got %h want %h on core%0d only", t, dload, ramload, g); else n_pass++;
      @(negedge CLK);
    end
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_stall();
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h40; ramstate = BUSY;
    ramload = 32'h7777_7777;
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      #2;
      n_checks++; if ({ramREN, ramaddr, dwait[0], dload[0]} !== {1'b1, 32'h40, 1'b1, 32'h0}) $display("FAIL stall%0d got %b %h %b %h want 1 40 1 0", k, ramREN, ramaddr, dwait[0], dload[0]); else n_pass++;
      @(negedge CLK);
    end
    ramstate = ACCESS;
    #2;
    n_checks++; if ({dwait[0], dload[0]} !== {1'b0, 32'h7777_7777}) $display("FAIL stall_done got %b %h want 0 77777777", dwait[0], dload[0]); else n_pass++;
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_abort_req();
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = BUSY;
    @(negedge CLK);
    #2;
    n_checks++; if (ramREN !== 1'b1) $display("FAIL ab_serve got %b want 1", ramREN); else n_pass++;
    @(negedge CLK);
    dREN[0] = 1'b0;
    #2;
    n_checks++; if ({ramREN, ramWEN, ramaddr, dwait[0]} !== {2'b00, 32'h0, 1'b0}) $display("FAIL ab_drop got %b%b %h %b want 00 0 0", ramREN, ramWEN, ramaddr, dwait[0]); else n_pass++;
    @(negedge CLK);
    dREN = 2'b11;
    #2;
    n_checks++; if (ramREN !== 1'b0) $display("FAIL ab_idle got %b want 0", ramREN); else n_pass++;
    @(negedge CLK);
    #2;
    n_checks++; if (ramaddr !== 32'h10) $display("FAIL ab_rr got %h want 10", ramaddr); else n_pass++;
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_abort_reset();
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = ACCESS;
    @(negedge CLK);
    @(negedge CLK);
    dREN[1] = 1'b1; ramstate = BUSY;
    @(negedge CLK);
    #2;
    n_checks++; if (ramaddr !== 32'h20) $display("FAIL abr_grant got %h want 20", ramaddr); else n_pass++;
    RST = 1'b1; ramstate = ACCESS; ramload = 32'hABCD;
    #1;
    n_checks++; if ({ramREN, ramWEN, ramaddr, dload} !== 98'h0) $display("FAIL abr_outs got %b%b %h %h want 0", ramREN, ramWEN, ramaddr, dload); else n_pass++;
    n_checks++; if (dwait !== 2'b11) $display("FAIL abr_wait got %b want 11", dwait); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    #2;
    n_checks++; if (ramREN !== 1'b0) $display("FAIL abr_idle got %b want 0", ramREN); else n_pass++;
    @(negedge CLK);
    #2;
    n_checks++; if (ramaddr !== 32'h10) $display("FAIL abr_rr got %h want 10", ramaddr); else n_pass++;
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_random();
    bit               busy, still, drive, comp;
    int               core, kind, rr;
    logic [65:0]      exp_ram;
    logic [3:0]       exp_w;
    logic [1:0][31:0] exp_il, exp_dl;
    do_reset();
    busy = 1'b0; rr = 0; core = 0; kind = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      RST = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 2; c++) begin
        iREN[c] = iREN[c] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        dREN[c] = dREN[c] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        dWEN[c] = dWEN[c] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        if (!iREN[c]) iaddr[c] = $urandom;
        if (!dREN[c] && !dWEN[c]) begin
          daddr[c] = $urandom;
          dstore[c] = $urandom;
        end
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload = $urandom;
      #2;
      still = 1'b0;
      if (busy) still = (kind == 0) ? iREN[core] : (kind == 1) ? dREN[core] : dWEN[core];
      drive = busy && !RST && still;
      comp = drive && (ramstate == ACCESS);
      exp_ram = '0;
      if (drive) exp_ram = {kind != 2, kind == 2, (kind == 0) ? iaddr[core] : daddr[core], (kind == 2) ? dstore[core] : 32'h0};
      exp_w = {iREN, dREN | dWEN};
      exp_il = '0;
      exp_dl = '0;
      if (comp && kind == 0) begin exp_w[2 + core] = 1'b0; exp_il[core] = ramload; end
      if (comp && kind != 0) exp_w[core] = 1'b0;
      if (comp && kind == 1) exp_dl[core] = ramload;
      n_checks++; if ({ramREN, ramWEN, ramaddr, ramstore} !== exp_ram) $display("FAIL rnd_ram c%0d got %h want %h", cyc, {ramREN, ramWEN, ramaddr, ramstore}, exp_ram); else n_pass++;
      n_checks++; if ({iwait, dwait} !== exp_w) $display("FAIL rnd_wait c%0d got %b want %b", cyc, {iwait, dwait}, exp_w); else n_pass++;
      n_checks++; if ({iload, dload} !== {exp_il, exp_dl}) $display("FAIL rnd_load c%0d got %h want %h", cyc, {iload, dload}, {exp_il, exp_dl}); else n_pass++;
      if (RST) begin
        busy = 1'b0; rr = 0;
      end else if (!busy) begin
        if (|(iREN | dREN | dWEN)) begin
          core = (iREN[rr] | dREN[rr] | dWEN[rr]) ? rr : 1 - rr;
          kind = dREN[core] ? 1 : dWEN[core] ? 2 : 0;
          busy = 1'b1;
        end
      end else if (!still || comp) begin
        busy = 1'b0;
        if (comp) rr = 1 - core;
      end
      @(negedge CLK);
    end
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_stall();
    test_abort_req();
    test_abort_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
